stream_frame_regulator: RTL and testbench

- Per-channel stage directly downstream of the two-output tdest stream switch. One instance is attached to each switch master port.
- Takes the routed AXI4-Stream video for one virtual channel and rebuilds clean frame geometry: SOF aligned, exactly H_ACTIVE beats per line and V_ACTIVE lines per frame.
- Fixes malformed lines by padding or dropping, and reports errors, so that the frame buffer writer always sees well-formed frames.

---
 rtl/video_stream_pkg.sv | 21 ++
 rtl/stream_out_reg.sv | 39 +++
 rtl/stream_frame_regulator.sv | 208 ++++++++++++++++++++
 tb/tb_stream_frame_regulator.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_stream_pkg.sv
// Shared video stream definitions: frame regulator states, error flag bit positions,
// and the virtual channel IDs used by the tdest switch and its per-channel regulators.
package video_stream_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        PAD      = 2'd2,
        DROP     = 2'd3
    } reg_state_t;

    localparam int ERR_SHORT_LINE  = 0;
    localparam int ERR_LONG_LINE   = 1;
    localparam int ERR_SHORT_FRAME = 2;
    localparam int ERR_FOREIGN     = 3;
    localparam int ERR_W           = 4;

    localparam logic [9:0] CH_ID_A = 10'h2c0;
    localparam logic [9:0] CH_ID_B = 10'h2c1;

endpackage

// File: rtl/stream_out_reg.sv
// One-stage AXIS output register; 1-cycle latency from load to m_axis_tvalid.
// Loads whenever empty or draining; contents stay frozen while stalled by m_axis_tready.
module stream_out_reg #(
    parameter int WIDTH       = 16,
    parameter int TUSER_WIDTH = 1
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   in_vld,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    input  logic [TUSER_WIDTH-1:0] in_user,
    output logic                   load,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [WIDTH-1:0]       m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser
);

    assign load = !m_axis_tvalid || m_axis_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (load) begin
            m_axis_tvalid <= in_vld;
            if (in_vld) begin
                m_axis_tdata <= in_data;
                m_axis_tlast <= in_last;
                m_axis_tuser <= in_user;
            end
        end
    end

endmodule

// File: rtl/stream_frame_regulator.sv
// Rebuilds SOF-aligned H_ACTIVE x V_ACTIVE frames for one channel (pad/drop, error flags); 1-cycle latency.
// Input ready follows the output register in WAIT_SOF/ACTIVE, is 0 while padding, 1 while dropping.
module stream_frame_regulator
    import video_stream_pkg::*;
#(
    parameter int                     WIDTH       = 16,
    parameter int                     TUSER_WIDTH = 1,
    parameter int                     TDEST_WIDTH = 10,
    parameter logic [TDEST_WIDTH-1:0] CHANNEL_ID  = CH_ID_A,
    parameter logic [15:0]            H_ACTIVE    = 16'd1920,
    parameter logic [15:0]            V_ACTIVE    = 16'd1080
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [WIDTH-1:0]       s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [WIDTH-1:0]       m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [TDEST_WIDTH-1:0] m_axis_tdest,
    output logic [15:0]            frame_cnt,
    output logic [ERR_W-1:0]       err_pulse,
    output logic [ERR_W-1:0]       err_sticky,
    input  logic                   err_clr
);

    reg_state_t             state, state_nxt;
    logic [15:0]            col_idx, col_nxt;
    logic [15:0]            line_idx, line_nxt;
    logic [ERR_W-1:0]       err_nxt;
    logic                   frame_end;

    logic                   load;
    logic                   out_vld;
    logic [WIDTH-1:0]       out_data;
    logic                   out_last;
    logic [TUSER_WIDTH-1:0] out_user;

    logic                   foreign;
    logic                   sof;
    logic                   eol;
    logic                   eof;
    logic                   frame_origin;
    logic [15:0]            col_adv;
    logic [15:0]            line_adv;

    assign m_axis_tdest = CHANNEL_ID;

    assign foreign      = s_axis_tvalid && (s_axis_tdest != CHANNEL_ID);
    assign sof          = s_axis_tuser[0];
    assign eol          = (col_idx == H_ACTIVE - 16'd1);
    assign eof          = eol && (line_idx == V_ACTIVE - 16'd1);
    assign frame_origin = (col_idx == 16'd0) && (line_idx == 16'd0);

    // Position after emitting the beat at (col_idx, line_idx); wraps to 0/0 at end of frame.
    assign col_adv  = eol ? 16'd0 : col_idx + 16'd1;
    assign line_adv = !eol ? line_idx : (eof ? 16'd0 : line_idx + 16'd1);

    always_comb begin
        state_nxt     = state;
        col_nxt       = col_idx;
        line_nxt      = line_idx;
        err_nxt       = '0;
        frame_end     = 1'b0;
        s_axis_tready = 1'b0;
        out_vld       = 1'b0;
        out_data      = s_axis_tdata;
        out_last      = 1'b0;
        out_user      = '0;

        if (foreign) begin
            s_axis_tready        = 1'b1;
            err_nxt[ERR_FOREIGN] = 1'b1;
        end else begin
            case (state)
                WAIT_SOF: begin
                    if (!sof) begin
                        s_axis_tready = 1'b1;
                    end else begin
                        s_axis_tready = load;
                        if (s_axis_tvalid && load) begin
                            out_vld     = 1'b1;
                            out_user[0] = 1'b1;
                            col_nxt     = 16'd1;
                            line_nxt    = 16'd0;
                            state_nxt   = ACTIVE;
                        end
                    end
                end

                ACTIVE: begin
                    if (sof && !frame_origin) begin
                        // New frame arrived early: leave the SOF beat for WAIT_SOF to take.
                        if (s_axis_tvalid) begin
                            err_nxt[ERR_SHORT_FRAME] = 1'b1;
                            state_nxt                = WAIT_SOF;
                            col_nxt                  = 16'd0;
                            line_nxt                 = 16'd0;
                        end
                    end else begin
                        s_axis_tready = load;
                        if (s_axis_tvalid && load) begin
                            out_vld     = 1'b1;
                            out_user[0] = frame_origin;
                            out_last    = eol;
                            col_nxt     = col_adv;
                            line_nxt    = line_adv;
                            if (eol && !s_axis_tlast) begin
                                err_nxt[ERR_LONG_LINE] = 1'b1;
                            end
                            if (!eol && s_axis_tlast) begin
                                err_nxt[ERR_SHORT_LINE] = 1'b1;
                                state_nxt               = PAD;
                            end else if (eof) begin
                                frame_end = 1'b1;
                                state_nxt = WAIT_SOF;
                            end else if (eol && !s_axis_tlast) begin
                                state_nxt = DROP;
                            end
                        end
                    end
                end

                PAD: begin
                    if (load) begin
                        out_vld  = 1'b1;
                        out_data = '0;
                        out_last = eol;
                        col_nxt  = col_adv;
                        line_nxt = line_adv;
                        if (eof) begin
                            frame_end = 1'b1;
                            state_nxt = WAIT_SOF;
                        end else if (eol) begin
                            state_nxt = ACTIVE;
                        end
                    end
                end

                DROP: begin
                    if (sof) begin
                        if (s_axis_tvalid) begin
                            err_nxt[ERR_SHORT_FRAME] = 1'b1;
                            state_nxt                = WAIT_SOF;
                            col_nxt                  = 16'd0;
                            line_nxt                 = 16'd0;
                        end
                    end else begin
                        s_axis_tready = 1'b1;
                        if (s_axis_tvalid && s_axis_tlast) begin
                            state_nxt = ACTIVE;
                        end
                    end
                end

                default: begin
                    state_nxt = WAIT_SOF;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= WAIT_SOF;
            col_idx    <= '0;
            line_idx   <= '0;
            frame_cnt  <= '0;
            err_pulse  <= '0;
            err_sticky <= '0;
        end else begin
            state      <= state_nxt;
            col_idx    <= col_nxt;
            line_idx   <= line_nxt;
            err_pulse  <= err_nxt;
            // A flag raised in the same cycle as err_clr survives the clear.
            err_sticky <= (err_clr ? '0 : err_sticky) | err_nxt;
            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    stream_out_reg #(
        .WIDTH       (WIDTH),
        .TUSER_WIDTH (TUSER_WIDTH)
    ) u_out_reg (
        .aclk          (aclk),
        .areset        (areset),
        .in_vld        (out_vld),
        .in_data       (out_data),
        .in_last       (out_last),
        .in_user       (out_user),
        .load          (load),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

endmodule

// File: tb/tb_stream_frame_regulator.sv
// Bench for stream_frame_regulator with an 8x4 frame geometry: directed line/frame scenarios,
// a line-level expected-output model, and a per-cycle output checker.
module tb_stream_frame_regulator;
    import video_stream_pkg::*;

    localparam int          H = 8;
    localparam int          V = 4;
    localparam logic [15:0] H_P = 16'd8;
    localparam logic [15:0] V_P = 16'd4;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic [0:0]  s_axis_tuser = '0;
    logic [9:0]  s_axis_tdest = CH_ID_A;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic [9:0]  m_axis_tdest;
    logic [15:0] frame_cnt;
    logic [3:0]  err_pulse;
    logic [3:0]  err_sticky;
    logic        err_clr = 1'b0;

    always #5 aclk = ~aclk;

    stream_frame_regulator #(
        .WIDTH       (16),
        .TUSER_WIDTH (1),
        .TDEST_WIDTH (10),
        .CHANNEL_ID  (CH_ID_A),
        .H_ACTIVE    (H_P),
        .V_ACTIVE    (V_P)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tdest  (s_axis_tdest),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tdest  (m_axis_tdest),
        .frame_cnt     (frame_cnt),
        .err_pulse     (err_pulse),
        .err_sticky    (err_sticky),
        .err_clr       (err_clr)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          out_cnt = 0;
    int          last_cnt = 0;
    int          user_cnt = 0;
    int          pulse_cnt [4];
    logic [31:0] exp_q [$];
    bit          bp_en = 1'b0;
    logic        stalled_prev = 1'b0;
    logic [31:0] hold_beat = '0;
    logic [31:0] mon_got;

    function automatic logic [31:0] pack(input logic [9:0] dest, input logic [15:0] d,
                                         input logic last, input logic user);
        return {4'b0000, dest, d, last, user};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Model: every terminated input line becomes exactly H output beats (input data, then zero fill);
    // a line cut off by an early SOF yields only the beats that actually arrived, with no end marker.
    task automatic expect_line(input int n, input bit sof, input bit term, input int base);
        int k_end;
        k_end = term ? H : n;
        for (int k = 0; k < k_end; k++) begin
            exp_q.push_back(pack(CH_ID_A, (k < n) ? 16'(base + k) : 16'h0000,
                                 term && (k == H - 1), sof && (k == 0)));
        end
    endtask

    always @(negedge aclk) begin
        mon_got = pack(m_axis_tdest, m_axis_tdata, m_axis_tlast, m_axis_tuser[0]);
        if (stalled_prev) begin
            check("stall_valid", 32'(m_axis_tvalid), 32'd1);
            check("stall_data", mon_got, hold_beat);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL extra_beat: got 0x%0h, expected no beat", mon_got);
            end else begin
                check("beat", mon_got, exp_q.pop_front());
            end
            out_cnt++;
            if (m_axis_tlast) last_cnt++;
            if (m_axis_tuser[0]) user_cnt++;
        end
        stalled_prev = !areset && m_axis_tvalid && !m_axis_tready;
        hold_beat    = mon_got;
        for (int b = 0; b < 4; b++) begin
            if (err_pulse[b]) pulse_cnt[b]++;
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_beat(input logic [15:0] d, input bit last, input bit sof, input logic [9:0] dest);
        bit ok;
        s_axis_tvalid   = 1'b1;
        s_axis_tdata    = d;
        s_axis_tlast    = last;
        s_axis_tuser[0] = sof;
        s_axis_tdest    = dest;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge aclk);
            ok = s_axis_tready;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: tready 0 for 200 cycles, expected 1 (data 0x%0h)", d);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_line(input int n, input bit sof, input bit term, input int base, input bit mix);
        expect_line(n, sof, term, base);
        for (int i = 0; i < n; i++) begin
            if (mix && (i % 3 == 1)) begin
                send_beat(16'hBAD0 | 16'(i), i[0], 1'b0, CH_ID_B);
            end
            send_beat(16'(base + i), term && (i == n - 1), sof && (i == 0), CH_ID_A);
        end
    endtask

    task automatic send_full_frame(input int tbase, input bit mix);
        for (int l = 0; l < V; l++) begin
            send_line(H, l == 0, 1'b1, tbase + l * 16, mix);
        end
    endtask

    task automatic start_test();
        out_cnt  = 0;
        last_cnt = 0;
        user_cnt = 0;
        for (int b = 0; b < 4; b++) pulse_cnt[b] = 0;
    endtask

    task automatic finish_test(input string name, input int e_out, input int e_last, input int e_user,
                               input int e_frames, input logic [3:0] e_sticky);
        for (int c = 0; c < 1000 && exp_q.size() != 0; c++) @(negedge aclk);
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        repeat (5) @(posedge aclk);
        #1;
        check({name, "_out_cnt"}, 32'(out_cnt), 32'(e_out));
        check({name, "_last_cnt"}, 32'(last_cnt), 32'(e_last));
        check({name, "_user_cnt"}, 32'(user_cnt), 32'(e_user));
        check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(e_frames));
        check({name, "_err_sticky"}, 32'(err_sticky), 32'(e_sticky));
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge aclk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tuser", 32'(m_axis_tuser), 32'd0);
        check("rst_tdest", 32'(m_axis_tdest), 32'h2c0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // Clean frame.
        start_test();
        send_full_frame(16'h0100, 1'b0);
        finish_test("clean", 32, 4, 1, 1, 4'b0000);

        // Short line 1: five beats then zero fill.
        start_test();
        send_line(8, 1'b1, 1'b1, 16'h0200, 1'b0);
        send_line(5, 1'b0, 1'b1, 16'h0210, 1'b0);
        send_line(8, 1'b0, 1'b1, 16'h0220, 1'b0);
        send_line(8, 1'b0, 1'b1, 16'h0230, 1'b0);
        finish_test("short", 32, 4, 1, 2, 4'b0001);
        check("short_pulse0", 32'(pulse_cnt[ERR_SHORT_LINE]), 32'd1);
        clear_err();

        // Long line 2: eleven beats, last three dropped.
        start_test();
        send_line(8, 1'b1, 1'b1, 16'h0300, 1'b0);
        send_line(8, 1'b0, 1'b1, 16'h0310, 1'b0);
        send_line(11, 1'b0, 1'b1, 16'h0320, 1'b0);
        send_line(8, 1'b0, 1'b1, 16'h0330, 1'b0);
        finish_test("long", 32, 4, 1, 3, 4'b0010);
        check("long_pulse1", 32'(pulse_cnt[ERR_LONG_LINE]), 32'd1);

        // Clear coinciding with a new error: the new flag must remain.
        err_clr = 1'b1;
        send_beat(16'h0BAD, 1'b0, 1'b0, CH_ID_B);
        err_clr = 1'b0;
        @(posedge aclk);
        #1;
        check("clr_vs_set_sticky", 32'(err_sticky), 32'h8);
        clear_err();

        // Early SOF at line 2 col 3, followed by a complete frame.
        start_test();
        send_line(8, 1'b1, 1'b1, 16'h0400, 1'b0);
        send_line(8, 1'b0, 1'b1, 16'h0410, 1'b0);
        send_line(3, 1'b0, 1'b0, 16'h0420, 1'b0);
        send_full_frame(16'h0500, 1'b0);
        finish_test("early_sof", 51, 6, 2, 4, 4'b0100);
        check("early_sof_pulse2", 32'(pulse_cnt[ERR_SHORT_FRAME]), 32'd1);
        clear_err();

        // Foreign tdest interleaved under random output backpressure.
        start_test();
        bp_en = 1'b1;
        send_full_frame(16'h0600, 1'b1);
        finish_test("foreign_bp", 32, 4, 1, 5, 4'b1000);
        check("foreign_pulse3", 32'(pulse_cnt[ERR_FOREIGN]), 32'd12);
        bp_en = 1'b0;
        @(posedge aclk);
        #1;
        clear_err();

        // Reset during line 1, then a fresh frame preceded by non-SOF junk.
        start_test();
        send_line(8, 1'b1, 1'b1, 16'h0700, 1'b0);
        send_line(3, 1'b0, 1'b0, 16'h0710, 1'b0);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        start_test();
        send_beat(16'h0777, 1'b0, 1'b0, CH_ID_A);
        send_beat(16'h0778, 1'b1, 1'b0, CH_ID_A);
        send_full_frame(16'h0800, 1'b0);
        finish_test("after_rst", 32, 4, 1, 1, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
